frag_serializer: RTL
====================

FRAG_SERIALIZER -- requirements
Module: frag_serializer

Interface
REQ-001 SHALL have parameters: SIGFIG, default 24, bits per coordinate/color; RADIX, default 10, fraction bits; AXIS, default 3, axes per hit (x,y,z); COLORS, default 3, color channels; LANES, default 4, parallel hit lanes; DEPTH, default 4, beat buffer entries (power of two, >=2).
REQ-002 SHALL have ports: clk, input, 1, sole clock (rising edge); rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports: hit_R18S, input, [LANES][AXIS] x SIGFIG signed, per-lane hit position and depth; color_R18U, input, [LANES][COLORS] x SIGFIG unsigned, per-lane color; hit_valid_R18H, input, LANES, per-lane valid mask.
REQ-004 SHALL have port: halt_RnnnnL, output, 1, upstream stall, active low; 0 means the input beat is not accepted.
REQ-005 SHALL have ports: hit_R19S, output, [AXIS] x SIGFIG signed; color_R19U, output, [COLORS] x SIGFIG unsigned; hit_valid_R19H, output, 1, single-fragment stream toward the z-buffer.
REQ-006 SHALL have port: halt_R19L, input, 1, downstream stall, active low; a fragment transfers on a rising edge where hit_valid_R19H=1 and halt_R19L=1.

Function
REQ-007 SHALL accept a beat (all lanes plus mask) on an edge where halt_RnnnnL=1, rst=0 and hit_valid_R18H!=0; a beat with an all-zero mask SHALL be dropped and no entry consumed.
REQ-008 SHALL drive halt_RnnnnL=1 iff occupancy<DEPTH; occupancy is the registered count only, so a pop in the same cycle does not let a full buffer accept.
REQ-009 SHALL present the lowest-index remaining valid lane of the head entry on hit_R19S/color_R19U with hit_valid_R19H=1 whenever occupancy>0.
REQ-010 SHALL, on each transfer, clear that lane bit in the head entry's mask; when the mask becomes zero the head entry SHALL pop in that same edge.
REQ-011 SHALL give latency of one cycle: a beat accepted at edge N into an empty buffer shows its first fragment after edge N.
REQ-012 SHALL sustain one fragment per cycle; a beat with k valid lanes SHALL occupy exactly k transfer cycles, back-to-back across entries.
REQ-013 SHALL hold output data and valid stable while halt_R19L=0.
REQ-014 SHALL leave occupancy unchanged on a simultaneous push and pop; read/write pointers SHALL wrap modulo DEPTH.
REQ-015 SHALL keep lane order within a beat and beat order across beats. No fragment may be lost or duplicated.

Reset
REQ-016 SHALL, with rst=1 at an edge, clear occupancy, pointers and head mask; hit_valid_R19H=0 and halt_RnnnnL=1 after that edge.
REQ-017 SHALL discard all buffered fragments on reset mid-drain and ignore inputs during rst.

Configuration
REQ-018 SHALL, with FRAG_SERIALIZER_STATS_EN defined, add outputs frags_in_R19U[31:0] (valid lanes accepted), frags_out_R19U[31:0] (transfers) and stall_R19U[31:0] (cycles with hit_valid_R19H=1, halt_R19L=0). These counters SHALL reset to 0 and wrap at 2^32.
REQ-019 SHALL, without FRAG_SERIALIZER_STATS_EN, omit those ports and counters entirely. Behaviour is otherwise identical.

Structure
REQ-020 SHALL take LANES and the fragment typedef (position, color) plus the beat typedef (LANES fragments plus mask) from the shared rasterizer package rast_pkg.
REQ-021 SHALL instantiate one combinational sub-module frag_lane_pick: lowest-set-bit priority encoder returning lane index and a found flag.

Verification
REQ-022 SHALL cover: reset, then one beat with mask 4'b0101 and lane0 x=0x001400, lane2 x=0x002800, halt_R19L=1 -> lane0 out the cycle after accept, lane2 the next cycle, then hit_valid_R19H=0.
REQ-023 SHALL cover: mask 4'b1111 with halt_R19L=0 for 3 cycles -> lane0 held stable for 3 cycles, then lanes 0..3 on 4 consecutive cycles.
REQ-024 SHALL cover: halt_R19L=0 and 5 beats offered -> halt_RnnnnL=0 after the 4th accept, 5th beat not accepted; on release the 4 beats drain in order and halt_RnnnnL returns to 1.
REQ-025 SHALL cover: beats with mask 4'b0000 interleaved with mask 4'b1000 beats -> only lane3 fragments emerge and occupancy never counts the empty beats.
REQ-026 SHALL cover: rst=1 mid-drain of a 4'b1111 beat -> hit_valid_R19H=0 next cycle, halt_RnnnnL=1, and no residual fragments after rst deasserts.
REQ-027 SHALL cover, with FRAG_SERIALIZER_STATS_EN: after REQ-023 stimulus -> frags_in_R19U=4, frags_out_R19U=4, stall_R19U=3.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared rasterizer types: fragment (position + color) and per-beat lane bundle.
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int LANES  = 4;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic signed [SIGFIG-1:0] coord_t;
  typedef logic        [SIGFIG-1:0] color_t;

  typedef struct packed {
    coord_t [AXIS-1:0]   pos;
    color_t [COLORS-1:0] col;
  } frag_t;

  typedef struct packed {
    frag_t [LANES-1:0] frag;
    logic  [LANES-1:0] mask;
  } beat_t;

  function automatic logic [LANE_W:0] lane_count(input logic [LANES-1:0] mask);
    logic [LANE_W:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {{LANE_W{1'b0}}, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/frag_serializer_if.sv
// Beat-in / fragment-out bus of the fragment serializer; both stalls are active low.
interface frag_serializer_if;
  import rast_pkg::*;

  coord_t [LANES-1:0][AXIS-1:0]   hit_R18S;
  color_t [LANES-1:0][COLORS-1:0] color_R18U;
  logic   [LANES-1:0]             hit_valid_R18H;
  logic                           halt_RnnnnL;

  coord_t [AXIS-1:0]              hit_R19S;
  color_t [COLORS-1:0]            color_R19U;
  logic                           hit_valid_R19H;
  logic                           halt_R19L;

  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H, halt_R19L,
    input  halt_RnnnnL, hit_R19S, color_R19U, hit_valid_R19H
  );

  modport slave (
    input  hit_R18S, color_R18U, hit_valid_R18H, halt_R19L,
    output halt_RnnnnL, hit_R19S, color_R19U, hit_valid_R19H
  );

endinterface

// File: rtl/frag_serializer_lane_pick.sv
// Lowest-set-bit priority encoder: index of the first remaining lane plus a found flag.
module frag_lane_pick #(
  parameter  int LANES = 4,
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask_i,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = {IW{1'b0}};
    found_o = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      idx_o   = mask_i[i] ? IW'(i) : idx_o;
      found_o = found_o | mask_i[i];
    end
  end

endmodule

// File: rtl/frag_serializer.sv
// Buffers multi-lane hit beats and emits them one fragment per cycle, lane order preserved.
// Optional FRAG_SERIALIZER_STATS_EN adds free-running in/out/stall fragment counters.
module frag_serializer
  import rast_pkg::*;
#(
  parameter int SIGFIG = rast_pkg::SIGFIG,
  parameter int RADIX  = rast_pkg::RADIX,
  parameter int AXIS   = rast_pkg::AXIS,
  parameter int COLORS = rast_pkg::COLORS,
  parameter int LANES  = rast_pkg::LANES,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  frag_serializer_if.slave     bus_if
`ifdef FRAG_SERIALIZER_STATS_EN
  ,
  output logic [31:0]          frags_in_R19U,
  output logic [31:0]          frags_out_R19U,
  output logic [31:0]          stall_R19U
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // Storage types come from rast_pkg, so the widths must agree with it.
  if (SIGFIG != rast_pkg::SIGFIG || RADIX != rast_pkg::RADIX || AXIS != rast_pkg::AXIS ||
      COLORS != rast_pkg::COLORS || LANES != rast_pkg::LANES ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
    $error("frag_serializer: parameters disagree with rast_pkg or DEPTH not a power of two");
  end

  frag_t [LANES-1:0] data_q [DEPTH];
  logic  [LANES-1:0] mask_q [DEPTH];
  logic  [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic  [CW-1:0]    count_q, count_d;

  beat_t             in_beat_s;
  logic  [LANES-1:0] head_mask_s, rest_mask_s;
  logic  [IW-1:0]    lane_idx_s;
  logic              lane_found_s;
  logic              out_valid_s, accept_s, xfer_s, pop_s;

  frag_lane_pick #(.LANES(LANES)) u_pick (
    .mask_i  (head_mask_s),
    .idx_o   (lane_idx_s),
    .found_o (lane_found_s)
  );

  // Gather the incoming lanes into one beat record.
  always_comb begin
    in_beat_s      = '0;
    in_beat_s.mask = bus_if.hit_valid_R18H;
    for (int l = 0; l < LANES; l++) begin
      in_beat_s.frag[l].pos = bus_if.hit_R18S[l];
      in_beat_s.frag[l].col = bus_if.color_R18U[l];
    end
  end

  // Handshake decode; fullness is judged on the registered count only.
  always_comb begin
    head_mask_s = mask_q[rd_ptr_q];
    out_valid_s = (count_q != {CW{1'b0}}) && lane_found_s;
    accept_s    = (count_q < FULL_C) && (|bus_if.hit_valid_R18H);
    xfer_s      = out_valid_s && bus_if.halt_R19L;
    rest_mask_s = head_mask_s & ~(LANES'(1'b1) << lane_idx_s);
    pop_s       = xfer_s && (rest_mask_s == {LANES{1'b0}});
    if (accept_s && !pop_s) begin
      count_d = count_q + CW'(1'b1);
    end else if (pop_s && !accept_s) begin
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  assign bus_if.halt_RnnnnL    = (count_q < FULL_C);
  assign bus_if.hit_valid_R19H = out_valid_s;
  assign bus_if.hit_R19S       = data_q[rd_ptr_q][lane_idx_s].pos;
  assign bus_if.color_R19U     = data_q[rd_ptr_q][lane_idx_s].col;

  // Payload storage needs no reset: it is only observed through a live mask.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      data_q[wr_ptr_q] <= in_beat_s.frag;
    end
  end

  // Pointers, occupancy and per-entry remaining-lane masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int e = 0; e < DEPTH; e++) begin
        mask_q[e] <= {LANES{1'b0}};
      end
    end else begin
      if (accept_s) begin
        mask_q[wr_ptr_q] <= in_beat_s.mask;
        wr_ptr_q         <= wr_ptr_q + PW'(1'b1);
      end
      if (xfer_s) begin
        mask_q[rd_ptr_q] <= rest_mask_s;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
      count_q <= count_d;
    end
  end

`ifdef FRAG_SERIALIZER_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      frags_in_R19U  <= 32'd0;
      frags_out_R19U <= 32'd0;
      stall_R19U     <= 32'd0;
    end else begin
      if (accept_s) begin
        frags_in_R19U <= frags_in_R19U + 32'(lane_count(bus_if.hit_valid_R18H));
      end
      if (xfer_s) begin
        frags_out_R19U <= frags_out_R19U + 32'd1;
      end
      if (out_valid_s && !bus_if.halt_R19L) begin
        stall_R19U <= stall_R19U + 32'd1;
      end
    end
  end
`endif

endmodule
